sipo_loader: RTL and testbench
==============================

# sipo_loader

Serial-in, parallel-out loader sitting directly upstream of a bank of WIDTH `dff_en` storage cells. It accepts one bit per cycle over a valid/ready handshake and assembles WIDTH bits into a word. It then presents the word on `word` and drives the bank's shared enable `word_en` for exactly one cycle when the downstream consumer accepts it. Partial words can be discarded with `abort`.

## Interface

Parameters:
- `WIDTH`, 8: bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = first received bit lands in `word[WIDTH-1]`; 0 = first received bit lands in `word[0]`.

Ports:
- `clk`  input  1  clock; all state changes on rising edge.
- `rst_n`  input  1  reset; synchronous, active-low.
- `s_data`  input  1  serial data bit.
- `s_valid`  input  1  `s_data` is valid this cycle.
- `s_ready`  output  1  loader accepts a bit this cycle.
- `abort`  input  1  synchronous discard of the current partial or held word.
- `word`  output  WIDTH  assembled word; drives the `d` inputs of the storage bank.
- `word_valid`  output  1  `word` is complete and stable.
- `word_ready`  input  1  downstream accepts `word` this cycle.
- `word_en`  output  1  load strobe to the storage bank's `en`.
- `bit_count`  output  clog2(WIDTH+1)  bits accepted into the current word.

## Operation

- Two-state FSM: FILL and HOLD.
- A bit transfers when `s_valid & s_ready`.
- Reset (rst_n=0 at a rising edge): state=FILL, shift register=0, `bit_count`=0, `word_valid`=0. While `rst_n`=0, `s_ready`=0 and `word_en`=0.
- FILL:
  - `s_ready`=1 (gated by `rst_n`), `word_valid`=0.
  - Each transfer shifts `s_data` in and increments `bit_count`.
  - MSB_FIRST=1: shift left, new bit enters bit 0.
  - MSB_FIRST=0: shift right, new bit enters bit WIDTH-1.
  - A transfer when `bit_count`=WIDTH-1 moves to HOLD with `bit_count`=WIDTH.
- HOLD:
  - `s_ready`=0, `word_valid`=1, `word` frozen.
  - `word_en` = `word_valid & word_ready & ~abort`, combinational.
  - A handshake (`word_en`=1) returns to FILL and clears `bit_count` to 0.
  - The shift register is not cleared. Stale bits are shifted out by the next word.
- `abort`=1 at a rising edge, in any state:
  - Next state FILL, `bit_count`=0, `word_valid`=0.
  - No bit accepted that cycle: `s_ready` is forced 0 while `abort`=1.
  - `word_en` is suppressed.
- Priority, highest first: reset, abort, word handshake, bit transfer.
- `bit_count` never exceeds WIDTH. It never wraps.
- `word` is the shift register, directly. Outside HOLD its value is don't-care to consumers.

## Timing

- `s_ready`, `word_valid` and `bit_count` are decoded from registered state. No input-to-output combinational path except `word_en` (from `word_ready` and `abort`) and `s_ready` (from `abort`).
- Latency: the last bit accepted at edge N gives `word_valid`=1 in the cycle after edge N.
- The earliest `word_en` is in that same cycle. The storage bank captures at edge N+1.
- Minimum period per word is WIDTH+1 cycles: WIDTH bit transfers plus one HOLD cycle. No bit is accepted during HOLD.
- `word_valid` stays high with `word` stable until the handshake or an abort. Downstream stall is unbounded.
- `s_valid` may drop at any time in FILL. The partial word is retained indefinitely.
- Reset mid-word or mid-HOLD takes effect at the next edge: the word is lost and no `word_en` pulse is produced.

## Test plan

- Reset, then WIDTH=8, MSB_FIRST=1, bits 1,0,1,0,0,1,0,1 back-to-back with `word_ready`=1:
  - `word_valid` rises the cycle after the 8th bit, `word`=8'hA5.
  - `word_en` high exactly 1 cycle, then `s_ready`=1 and `bit_count`=0.
- Same bits with MSB_FIRST=0 -> `word`=8'hA5 bit-reversed = 8'hA5. Then a second run with bits 1,1,0,0,0,0,0,0 -> `word`=8'h03.
- Complete word 8'h3C with `word_ready`=0 for 5 cycles:
  - `word_valid`=1 and `word`=8'h3C held all 5 cycles, `s_ready`=0, `word_en`=0, `s_valid` ignored.
  - `word_ready`=1 -> one `word_en` pulse.
- After 5 bits, assert `abort` for 1 cycle with `s_valid`=1:
  - That bit is not accepted and `bit_count`=0.
  - The next 8 bits 1,1,1,1,0,0,0,0 -> `word`=8'hF0.
- In HOLD, assert `abort` and `word_ready` together -> `word_en`=0, next cycle FILL with `word_valid`=0.
- Drop `rst_n` for 1 cycle after 3 bits -> `bit_count`=0 and `word`=0 next cycle, `s_ready`=0 during reset. The following 8 bits produce the correct word.

Source files
------------

// File: rtl/sipo_loader_if.sv
// Handshake bundle between a serial bit source, the SIPO loader and the
// downstream dff_en storage bank.
interface sipo_loader_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic          s_data;
    logic          s_valid;
    logic          s_ready;
    logic          abort;
    logic [WIDTH-1:0] word;
    logic          word_valid;
    logic          word_ready;
    logic          word_en;
    logic [CW-1:0] bit_count;

    modport slave (
        input  s_data, s_valid, abort, word_ready,
        output s_ready, word, word_valid, word_en, bit_count
    );

    modport master (
        output s_data, s_valid, abort, word_ready,
        input  s_ready, word, word_valid, word_en, bit_count
    );
endinterface

// File: rtl/sipo_loader.sv
// Serial-in parallel-out loader: assembles WIDTH bits into a word and strobes
// the storage bank enable once when the consumer accepts it.
module sipo_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    sipo_loader_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q, valid_d;
    logic             s_ready;
    logic             word_en;

    assign s_ready = rst_n & ~bus.abort & (state_q == FILL);
    assign word_en = rst_n & valid_q & bus.word_ready & ~bus.abort;

    assign bus.s_ready    = s_ready;
    assign bus.word_en    = word_en;
    assign bus.word       = shift_q;
    assign bus.word_valid = valid_q;
    assign bus.bit_count  = count_q;

    // Abort outranks the word handshake, which outranks a bit transfer.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        valid_d = valid_q;
        if (bus.abort) begin
            state_d = FILL;
            count_d = '0;
            valid_d = 1'b0;
        end else if (word_en) begin
            state_d = FILL;
            count_d = '0;
            valid_d = 1'b0;
        end else if (bus.s_valid && s_ready) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[WIDTH-2:0], bus.s_data};
            end else begin
                shift_d = {bus.s_data, shift_q[WIDTH-1:1]};
            end
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH - 1)) begin
                state_d = HOLD;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            shift_q <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_sipo_loader.sv
// Scoreboard bench: two loaders (MSB-first and LSB-first) share one serial
// stream and are checked against a bit-list reference model.
module tb_sipo_loader;
    localparam int WIDTH = 8;
    localparam int CW    = $clog2(WIDTH + 1);

    typedef struct {
        logic [WIDTH-1:0] w_msb;
        logic [WIDTH-1:0] w_lsb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_data = 1'b0;
    logic s_valid = 1'b0;
    logic word_ready = 1'b0;
    logic abort = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t exp_q[$];

    sipo_loader_if #(.WIDTH(WIDTH)) if_m ();
    sipo_loader_if #(.WIDTH(WIDTH)) if_l ();

    assign if_m.s_data = s_data;
    assign if_m.s_valid = s_valid;
    assign if_m.word_ready = word_ready;
    assign if_m.abort = abort;
    assign if_l.s_data = s_data;
    assign if_l.s_valid = s_valid;
    assign if_l.word_ready = word_ready;
    assign if_l.abort = abort;

    sipo_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(if_m.slave));
    sipo_loader #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(if_l.slave));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic sv, input logic sd, input logic wr, input logic ab);
        rst_n = rn;
        s_valid = sv;
        s_data = sd;
        word_ready = wr;
        abort = ab;
        @(posedge clk);
        #1;
    endtask

    // Bits are given first-received in the leftmost position of seq.
    task automatic sendBits(input logic [WIDTH-1:0] seq, input int n, input logic wr);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, seq[WIDTH-1-i], wr, 1'b0);
        end
    endtask

    // Reference model: the list of accepted bits; a full list is a held word.
    logic m_bits[WIDTH];
    int   m_cnt = 0;
    exp_t m_hold;

    always @(negedge clk) begin
        logic holding, exp_ready, exp_en;
        holding   = (m_cnt == WIDTH);
        exp_ready = rst_n && !abort && !holding;
        exp_en    = rst_n && holding && word_ready && !abort;

        checkOutput("s_ready_m", 32'(if_m.s_ready), 32'(exp_ready));
        checkOutput("s_ready_l", 32'(if_l.s_ready), 32'(exp_ready));
        checkOutput("word_valid_m", 32'(if_m.word_valid), 32'(holding));
        checkOutput("word_valid_l", 32'(if_l.word_valid), 32'(holding));
        checkOutput("bit_count_m", 32'(if_m.bit_count), 32'(m_cnt));
        checkOutput("bit_count_l", 32'(if_l.bit_count), 32'(m_cnt));
        checkOutput("word_en_m", 32'(if_m.word_en), 32'(exp_en));
        checkOutput("word_en_l", 32'(if_l.word_en), 32'(exp_en));
        if (holding) begin
            checkOutput("held_word_m", 32'(if_m.word), 32'(m_hold.w_msb));
            checkOutput("held_word_l", 32'(if_l.word), 32'(m_hold.w_lsb));
        end

        if (!rst_n || abort) begin
            if (holding && exp_q.size() > 0) void'(exp_q.pop_back());
            m_cnt = 0;
        end else if (exp_en) begin
            m_cnt = 0;
        end else if (s_valid && exp_ready) begin
            m_bits[m_cnt] = s_data;
            m_cnt++;
            if (m_cnt == WIDTH) begin
                m_hold.w_msb = '0;
                m_hold.w_lsb = '0;
                for (int i = 0; i < WIDTH; i++) begin
                    m_hold.w_msb = m_hold.w_msb | (WIDTH'(m_bits[i]) << (WIDTH - 1 - i));
                    m_hold.w_lsb = m_hold.w_lsb | (WIDTH'(m_bits[i]) << i);
                end
                exp_q.push_back(m_hold);
            end
        end
    end

    // Monitor: every load strobe must consume exactly one expected word.
    always @(negedge clk) begin
        exp_t e;
        if (if_m.word_en) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_word_en", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_word_m", 32'(if_m.word), 32'(e.w_msb));
                checkOutput("sb_word_l", 32'(if_l.word), 32'(e.w_lsb));
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        sendBits(8'b10100101, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        sendBits(8'b11000000, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        sendBits(8'b00111100, 8, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        sendBits(8'b10110000, 5, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        sendBits(8'b11110000, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        sendBits(8'b01101001, 8, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        sendBits(8'b11100000, 3, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("reset_word_m", 32'(if_m.word), 32'(0));
        checkOutput("reset_word_l", 32'(if_l.word), 32'(0));
        sendBits(8'b10011010, 8, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(99) != 0),
                          ($urandom_range(9) < 7),
                          1'($urandom_range(1)),
                          1'($urandom_range(1)),
                          ($urandom_range(19) == 0));
        end

        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
